// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared types, constants and the xtime helper for the AES-128
//               round sequencer and its Rcon generator.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

   // Round counter width; wide enough for NR up to 14
   localparam int unsigned ROUND_W = 4;

   // First round constant and the GF(2^8) reduction term used by xtime
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1B;

   // Sequencer state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_ROUND = ST_ROUND,
      S_HOLD  = ST_HOLD
   } seq_state_e;

   // Multiply by x in GF(2^8): shift left, reduce on carry out
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage : aes_ctrl_pkg
`default_nettype wire

// File: rtl/aes_rcon_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_rcon_gen
// Description : Round-constant register. clear returns it to 0x00 (no round
//               active); step loads RCON_INIT from zero, otherwise advances
//               by xtime. clear has priority over step.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rcon_gen
   import aes_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       step,
   output logic [7:0] rcon
);

   logic [7:0] rcon_q;
   logic [7:0] rcon_d;

   // Next Rcon: zero on clear, seed from zero, else xtime of the current value
   always_comb begin
      rcon_d = rcon_q;
      if (clear) begin
         rcon_d = 8'h00;
      end else if (step) begin
         rcon_d = (rcon_q == 8'h00) ? RCON_INIT : xtime(rcon_q);
      end
   end

   // Rcon register, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcon_q <= 8'h00;
      end else begin
         rcon_q <= rcon_d;
      end
   end

   assign rcon = rcon_q;

endmodule : aes_rcon_gen
`default_nettype wire

// File: rtl/aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_seq
// Description : Round sequencer for the iterative AES-128 core. Drives load,
//               round-enable, key-schedule and Rcon controls and holds the
//               result under a valid/ready handshake.
//               Optional macro AES_WDDL_PRECHARGE_EN inserts a precharge
//               cycle ahead of every LOAD/ROUND evaluate cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_seq
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned NR = 10
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   output logic               load_o,
   output logic               state_en_o,
   output logic               key_en_o,
   output logic [ROUND_W-1:0] round_o,
   output logic               final_round_o,
   output logic [7:0]         rcon_o,
   output logic               precharge_o,
   output logic               busy_o,
   output logic               result_valid_o,
   input  logic               result_ready_i
);

   localparam logic [ROUND_W-1:0] C_NR = ROUND_W'(NR);

   logic [1:0]         state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic               rcon_clear;
   logic               rcon_step;
   logic               eval;
   logic               in_step;

   assign in_step = (state_q == ST_LOAD) || (state_q == ST_ROUND);

`ifdef AES_WDDL_PRECHARGE_EN
   // Phase toggle: 0 = precharge, 1 = evaluate
   logic phase_q, phase_d;

   // Alternate PRE/EVAL inside LOAD and ROUND; park in PRE elsewhere
   always_comb begin
      phase_d = in_step ? ~phase_q : 1'b0;
   end

   // Phase register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign eval        = phase_q;
   assign precharge_o = ~(phase_q & in_step);
`else
   // Every step evaluates in a single cycle
   assign eval        = 1'b1;
   assign precharge_o = 1'b0;
`endif

   // Next-state, round counter and Rcon control
   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      rcon_clear = 1'b0;
      rcon_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (eval) begin
               state_d   = ST_ROUND;
               round_d   = {{(ROUND_W-1){1'b0}}, 1'b1};
               rcon_step = 1'b1;
            end
         end
         ST_ROUND: begin
            if (eval) begin
               if (round_q == C_NR) begin
                  state_d    = ST_HOLD;
                  round_d    = '0;
                  rcon_clear = 1'b1;
               end else begin
                  round_d   = round_q + 1'b1;
                  rcon_step = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (result_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            round_d    = '0;
            rcon_clear = 1'b1;
         end
      endcase
   end

   // FSM and round counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   aes_rcon_gen u_rcon (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (rcon_clear),
      .step  (rcon_step),
      .rcon  (rcon_o)
   );

   // Output decode straight from registered state
   assign load_o         = (state_q == ST_LOAD)  & eval;
   assign state_en_o     = (state_q == ST_ROUND) & eval;
   assign key_en_o       = (state_q == ST_ROUND) & eval;
   assign round_o        = round_q;
   assign final_round_o  = (state_q == ST_ROUND) & (round_q == C_NR);
   assign busy_o         = (state_q != ST_IDLE);
   assign result_valid_o = (state_q == ST_HOLD);

endmodule : aes_round_seq
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_seq
// Description : Self-checking bench for aes_round_seq with a cycle-level
//               behavioural model and directed literal checks.
//               Follows AES_WDDL_PRECHARGE_EN (NR = 14 on, NR = 10 off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_seq;

`ifdef AES_WDDL_PRECHARGE_EN
   localparam int   NR_TB     = 14;
   localparam int   P         = 2;
   localparam bit   WDDL      = 1'b1;
   localparam int   LAT       = 31;
   localparam int   FIRST_RND = 3;
   localparam logic [7:0] LAST_RCON = 8'h4D;
`else
   localparam int   NR_TB     = 10;
   localparam int   P         = 1;
   localparam bit   WDDL      = 1'b0;
   localparam int   LAT       = 12;
   localparam int   FIRST_RND = 2;
   localparam logic [7:0] LAST_RCON = 8'h36;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_i = 1'b0;
   logic       result_ready_i = 1'b0;
   logic       load_o, state_en_o, key_en_o, final_round_o;
   logic       precharge_o, busy_o, result_valid_o;
   logic [3:0] round_o;
   logic [7:0] rcon_o;

   int vec_cnt = 0;
   int err_cnt = 0;
   bit chk_en  = 1'b0;

   logic [7:0] rcon_tab [14];

   always #5 clk = ~clk;

   aes_round_seq #(.NR(NR_TB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .load_o         (load_o),
      .state_en_o     (state_en_o),
      .key_en_o       (key_en_o),
      .round_o        (round_o),
      .final_round_o  (final_round_o),
      .rcon_o         (rcon_o),
      .precharge_o    (precharge_o),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: mode 0 idle, 1 active, 2 hold -------
   int m_mode = 0;
   int m_t    = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0;
         m_t    <= 0;
      end else begin
         case (m_mode)
            0: if (start_i) begin m_mode <= 1; m_t <= 1; end
            1: if (m_t == P * (NR_TB + 1)) begin m_mode <= 2; m_t <= 0; end
               else m_t <= m_t + 1;
            default: if (result_ready_i) m_mode <= 0;
         endcase
      end
   end

   // Compare every output against the model on each falling edge
   int   e_step;
   bit   e_ev;
   logic e_load, e_en, e_final, e_pre, e_busy, e_valid;
   logic [3:0] e_round;
   logic [7:0] e_rcon;

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         e_load = 0; e_en = 0; e_final = 0; e_busy = 0; e_valid = 0;
         e_round = 0; e_rcon = 8'h00; e_pre = WDDL;
         if (m_mode == 1) begin
            e_step  = (m_t - 1) / P;
            e_ev    = (P == 1) || (((m_t - 1) % P) == 1);
            e_busy  = 1;
            e_load  = (e_step == 0) && e_ev;
            e_en    = (e_step > 0) && e_ev;
            e_round = 4'(e_step);
            e_rcon  = (e_step > 0) ? rcon_tab[e_step-1] : 8'h00;
            e_final = (e_step == NR_TB);
            e_pre   = WDDL && !e_ev;
         end else if (m_mode == 2) begin
            e_busy  = 1;
            e_valid = 1;
         end
         check("load_o",         32'(load_o),         32'(e_load));
         check("state_en_o",     32'(state_en_o),     32'(e_en));
         check("key_en_o",       32'(key_en_o),       32'(e_en));
         check("round_o",        32'(round_o),        32'(e_round));
         check("rcon_o",         32'(rcon_o),         32'(e_rcon));
         check("final_round_o",  32'(final_round_o),  32'(e_final));
         check("precharge_o",    32'(precharge_o),    32'(e_pre));
         check("busy_o",         32'(busy_o),         32'(e_busy));
         check("result_valid_o", 32'(result_valid_o), 32'(e_valid));
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic timeout_fail(input string name);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic wait_round(input logic [3:0] r);
      int n = 0;
      while (round_o !== r && n < 200) begin tick(); n++; end
      if (n >= 200) timeout_fail("wait_round");
   endtask

   task automatic wait_valid();
      int n = 0;
      while (result_valid_o !== 1'b1 && n < 200) begin tick(); n++; end
      if (n >= 200) timeout_fail("wait_valid");
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // ---------------- directed sequence --------------------------------------
   initial begin
      int vseen;
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                   8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

      // Reset then idle
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (5) tick();
      check("idle_busy",  32'(busy_o),      32'd0);
      check("idle_round", 32'(round_o),     32'd0);
      check("idle_pre",   32'(precharge_o), 32'(WDDL));

      // Nominal run: cycle 0 has start high
      start_i = 1'b1;
      for (int c = 1; c <= LAT; c++) begin
         tick();
         start_i = 1'b0;
         if (c == 1)           check("nom_load_c1",  32'(load_o), P == 1 ? 32'd1 : 32'd0);
         if (c == FIRST_RND)   check("nom_round1",   32'(round_o), 32'd1);
         if (c == FIRST_RND)   check("nom_rcon1",    32'(rcon_o),  32'h01);
         if (c == LAT - 1)     check("nom_lastrnd",  32'(round_o), 32'(NR_TB));
         if (c == LAT - 1)     check("nom_lastrcon", 32'(rcon_o),  32'(LAST_RCON));
         if (c == LAT - 1)     check("nom_final",    32'(final_round_o), 32'd1);
         if (c == LAT - 1)     check("nom_novalid",  32'(result_valid_o), 32'd0);
      end
      check("nom_valid_at_lat", 32'(result_valid_o), 32'd1);

      // Backpressure: 7 cycles without ready, then accept
      repeat (7) tick();
      check("bp_valid_held", 32'(result_valid_o), 32'd1);
      check("bp_en_low",     32'(state_en_o),     32'd0);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      check("bp_idle_after", 32'(busy_o), 32'd0);

      // Start while busy: in round 5 and in the acceptance cycle
      pulse_start();
      wait_round(4'd5);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("busy_start_round", 32'(round_o), P == 1 ? 32'd6 : 32'd5);
      wait_valid();
      result_ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      start_i = 1'b0;
      check("accept_idle",   32'(busy_o), 32'd0);
      tick();
      check("accept_noload", 32'(load_o), 32'd0);
      check("accept_nobusy", 32'(busy_o), 32'd0);
      pulse_start();
      check("restart_busy",  32'(busy_o), 32'd1);

      // Reset mid-operation in round 7
      wait_round(4'd7);
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy",  32'(busy_o),         32'd0);
      check("rst_round", 32'(round_o),        32'd0);
      check("rst_rcon",  32'(rcon_o),         32'h00);
      check("rst_en",    32'(state_en_o),     32'd0);
      check("rst_valid", 32'(result_valid_o), 32'd0);
      check("rst_pre",   32'(precharge_o),    32'(WDDL));
      tick();
      rst_n = 1'b1;
      vseen = 0;
      for (int i = 0; i < 2 * P * NR_TB + 10; i++) begin
         tick();
         if (result_valid_o === 1'b1) vseen++;
      end
      check("rst_no_valid_pulse", 32'(vseen), 32'd0);

      // Final short run to confirm recovery after reset
      pulse_start();
      wait_valid();
      check("post_rst_valid", 32'(result_valid_o), 32'd1);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_aes_round_seq
`default_nettype wire

// File: doc/aes_round_seq.md
# aes_round_seq

Round sequencer for the iterative AES-128 core. It accepts a start request, then drives the load, round-enable, key-schedule and Rcon controls of the state and key datapaths built from the standard-cell and WDDL gate netlists. It holds the finished result under a valid/ready handshake. With the WDDL option compiled in, every datapath evaluation is preceded by a precharge cycle.

## Interface
- NR, default 10: number of AES rounds; legal values 10, 12 or 14; sets the `round_o` count limit.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  begin encryption; sampled only in IDLE.
- load_o  output  1  load plaintext XOR key into the state register and the key into the key register.
- state_en_o  output  1  state register captures the round result.
- key_en_o  output  1  key register advances one key-expansion step.
- round_o  output  4  current round, 1..NR; 0 outside rounds.
- final_round_o  output  1  current round is NR; the datapath bypasses MixColumns.
- rcon_o  output  8  round constant for `round_o`; 0x00 outside rounds.
- precharge_o  output  1  WDDL precharge phase; tied 0 without the macro.
- busy_o  output  1  high in every state except IDLE.
- result_valid_o  output  1  ciphertext is stable in the state register.
- result_ready_i  input  1  consumer accepts the result.

## Operation
- FSM states: IDLE, LOAD, ROUND, HOLD.
- IDLE → LOAD when `start_i` = 1.
- LOAD → ROUND with round 1.
- ROUND at round r → ROUND at r+1 while r < NR.
- ROUND at round NR → HOLD.
- HOLD → IDLE when `result_ready_i` = 1.
- LOAD: `load_o` = 1 for exactly one evaluate cycle. This covers the initial AddRoundKey.
- ROUND: `state_en_o` = `key_en_o` = 1 in each evaluate cycle.
- `rcon_o` sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36, then 6C, D8, AB, 4D for NR > 10. Each step is xtime (shift left one bit; XOR 0x1B on carry out).
- HOLD: `result_valid_o` = 1 and all enables are 0. The result stays stable until accepted.
- The result is accepted in the cycle where `result_valid_o` and `result_ready_i` are both 1.
- `start_i` outside IDLE is ignored. This includes HOLD in the acceptance cycle; a new start is taken only in IDLE, one cycle later.
- `result_ready_i` outside HOLD is ignored.
- Reset, asynchronous at any time including mid-round: FSM goes to IDLE, the round counter and Rcon clear, and all outputs return to reset values. No partial result is flagged.

## Timing
- Reset values:
  - `load_o`, `state_en_o`, `key_en_o`, `final_round_o`, `busy_o`, `result_valid_o` = 0.
  - `round_o` = 0 and `rcon_o` = 0x00.
  - `precharge_o` = 1 with the macro, 0 without.
- All outputs are registered and decoded from FSM state; there are no combinational paths from inputs to outputs.
- Without the macro, for `start_i` high at cycle 0 with NR = 10:
  - LOAD in cycle 1.
  - Rounds 1..10 in cycles 2..11.
  - `result_valid_o` high from cycle 12.
  - Start-to-valid latency is NR+2 cycles.
- With the macro:
  - Each LOAD and ROUND step is a precharge cycle followed by an evaluate cycle. `load_o`, `state_en_o` and `key_en_o` are high only in the evaluate cycle.
  - `round_o`, `rcon_o` and `final_round_o` are held across both cycles of a round.
  - Latency is 2·NR+3 cycles; `result_valid_o` is high from cycle 23 for NR = 10.
- `done` back to `busy_o` = 0: IDLE is reached one cycle after acceptance.

## Configuration
- Macro `AES_WDDL_PRECHARGE_EN`.
- Defined:
  - A PRE/EVAL phase toggle is added.
  - `precharge_o` = 1 in IDLE, HOLD and every PRE cycle.
  - `precharge_o` = 0 only in EVAL cycles of LOAD and ROUND.
- Undefined:
  - No phase toggle; every step is one cycle.
  - `precharge_o` is constant 0.

## Structure
- Package `aes_ctrl_pkg`:
  - FSM state enum.
  - Constants `RCON_INIT` = 8'h01 and `RCON_POLY` = 8'h1B.
  - Function `xtime`.
  - Round-count width localparam (4 bits).
- Sub-module `aes_rcon_gen` holds the Rcon register. It has inputs clear and step and output `rcon`, and uses `xtime`.
- Everything else is in `aes_round_seq`.

## Test plan
- Reset then idle: hold `rst_n` = 0, release, wait 5 cycles with `start_i` = 0 → all outputs at reset values and `busy_o` = 0.
- Nominal, macro off, NR = 10: start pulse at cycle 0 → `load_o` only in cycle 1; `round_o` 1..10 in cycles 2..11; `rcon_o` 01..36 in step with `round_o`; `final_round_o` only in cycle 11; `result_valid_o` from cycle 12.
- Backpressure: hold `result_ready_i` = 0 for 7 cycles in HOLD → `result_valid_o` stays 1 and enables stay 0; raise ready → IDLE next cycle.
- Start during busy: pulse `start_i` in round 5 and again in the HOLD acceptance cycle → both are ignored; `round_o` is unaffected and the next LOAD follows only a start taken in IDLE.
- Reset mid-operation: assert `rst_n` = 0 during round 7 → all outputs are at reset values immediately (asynchronous), and no `result_valid_o` pulse appears afterwards.
- Macro on, NR = 14: `precharge_o` alternates 1/0 through LOAD and the rounds; each enable is high only when `precharge_o` = 0; `rcon_o` ends at 4D; `result_valid_o` is high at cycle 31.
